// File: rtl/rename_table.sv
// rename_table: register alias table sitting in front of the reorder buffer.
// Each architectural register holds a busy bit and the ROB tag of its newest
// in-flight producer. Source lookups are combinational from registered state.
// Issue writes and commit clears take effect at the next rising edge.
module rename_table #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             issue_has_dest,
  input  logic [4:0]       issue_dest,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  output logic             src1_busy,
  output logic             src2_busy,
  output logic [TAG_W-1:0] src1_tag,
  output logic [TAG_W-1:0] src2_tag,
  input  logic             commit1,
  input  logic             commit2,
  input  logic [4:0]       commit_addr,
  input  logic [4:0]       commit_addr2,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [TAG_W-1:0] commit_tag2,
  input  logic             flush,
  output logic [5:0]       busy_count
);

  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic [NUM_REGS-1:0][TAG_W-1:0] map_q, map_d;
  logic [5:0]                     busy_count_q;

  logic issue_wr_s;
  logic commit1_hit_s;
  logic commit2_hit_s;

  // Number of set bits in a busy vector.
  function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  // A commit only retires a mapping that still names the committing entry;
  // a mismatch means a younger producer has since renamed the register.
  assign commit1_hit_s = commit1 & busy_q[commit_addr]  & (map_q[commit_addr]  == commit_tag);
  assign commit2_hit_s = commit2 & busy_q[commit_addr2] & (map_q[commit_addr2] == commit_tag2);
  assign issue_wr_s    = issue & issue_has_dest & (issue_dest != 5'd0);

  // Source lookups from registered state only; the issuing instruction's own
  // destination write is never forwarded.
  always_comb begin
    src1_busy = busy_q[src1];
    src2_busy = busy_q[src2];
    if (busy_q[src1]) begin
      src1_tag = map_q[src1];
    end else begin
      src1_tag = {TAG_W{1'b0}};
    end
    if (busy_q[src2]) begin
      src2_tag = map_q[src2];
    end else begin
      src2_tag = {TAG_W{1'b0}};
    end
  end

  // Next-state table: flush beats everything, then the issue write is applied
  // after the commit clears so it wins on a shared register.
  always_comb begin
    busy_d = busy_q;
    map_d  = map_q;
    if (flush) begin
      busy_d = {NUM_REGS{1'b0}};
      map_d  = '0;
    end else begin
      busy_d[commit_addr]  = busy_d[commit_addr]  & ~commit1_hit_s;
      busy_d[commit_addr2] = busy_d[commit_addr2] & ~commit2_hit_s;
      busy_d[issue_dest]   = busy_d[issue_dest] | issue_wr_s;
      map_d[issue_dest]    = issue_wr_s ? issue_tag : map_d[issue_dest];
    end
    // Register 0 is hard-wired and never renamed.
    busy_d[0] = 1'b0;
    map_d[0]  = {TAG_W{1'b0}};
  end

  // State registers; busy_count tracks the popcount of the new busy vector so
  // it always matches the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= {NUM_REGS{1'b0}};
      map_q        <= '0;
      busy_count_q <= 6'd0;
    end else begin
      busy_q       <= busy_d;
      map_q        <= map_d;
      busy_count_q <= popcount(busy_d);
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_rename_table.sv
// Scoreboard bench for rename_table: the stimulus process computes the expected
// lookup/count response from a behavioural model and queues it; a separate
// monitor compares the DUT outputs every cycle.
module tb_rename_table;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue = 1'b0, issue_has_dest = 1'b0;
  logic [4:0] issue_dest = 5'd0, issue_tag = 5'd0;
  logic [4:0] src1 = 5'd0, src2 = 5'd0;
  logic       src1_busy, src2_busy;
  logic [4:0] src1_tag, src2_tag;
  logic       commit1 = 1'b0, commit2 = 1'b0;
  logic [4:0] commit_addr = 5'd0, commit_addr2 = 5'd0;
  logic [4:0] commit_tag = 5'd0, commit_tag2 = 5'd0;
  logic       flush = 1'b0;
  logic [5:0] busy_count;

  rename_table #(.NUM_REGS(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue(issue), .issue_has_dest(issue_has_dest),
    .issue_dest(issue_dest), .issue_tag(issue_tag),
    .src1(src1), .src2(src2),
    .src1_busy(src1_busy), .src2_busy(src2_busy),
    .src1_tag(src1_tag), .src2_tag(src2_tag),
    .commit1(commit1), .commit2(commit2),
    .commit_addr(commit_addr), .commit_addr2(commit_addr2),
    .commit_tag(commit_tag), .commit_tag2(commit_tag2),
    .flush(flush), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b1; int t1; int b2; int t2; int cnt; int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: what each register currently holds.
  bit busy_m[32];
  int map_m[32];

  task automatic chk(input string name, input int got, input int exp, input int c);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a lookup result; compare mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("src1_busy",  int'(src1_busy),  e.b1,  e.cyc);
      chk("src1_tag",   int'(src1_tag),   e.t1,  e.cyc);
      chk("src2_busy",  int'(src2_busy),  e.b2,  e.cyc);
      chk("src2_tag",   int'(src2_tag),   e.t2,  e.cyc);
      chk("busy_count", int'(busy_count), e.cnt, e.cyc);
    end
  end

  // Drive one cycle of inputs, queue the expected response, advance the model.
  task automatic step(input int iss, input int hd, input int dst, input int tg,
                      input int s1, input int s2,
                      input int c1, input int ca1, input int ct1,
                      input int c2, input int ca2, input int ct2,
                      input int fl, input int rs);
    exp_t e;
    bit   nb[32];
    int   nm[32];
    issue = iss[0]; issue_has_dest = hd[0];
    issue_dest = dst[4:0]; issue_tag = tg[4:0];
    src1 = s1[4:0]; src2 = s2[4:0];
    commit1 = c1[0]; commit_addr = ca1[4:0]; commit_tag = ct1[4:0];
    commit2 = c2[0]; commit_addr2 = ca2[4:0]; commit_tag2 = ct2[4:0];
    flush = fl[0]; rst = rs[0];
    e.b1  = busy_m[s1];
    e.t1  = busy_m[s1] ? map_m[s1] : 0;
    e.b2  = busy_m[s2];
    e.t2  = busy_m[s2] ? map_m[s2] : 0;
    e.cnt = 0;
    for (int r = 0; r < 32; r++) e.cnt += int'(busy_m[r]);
    e.cyc = cyc;
    sb_q.push_back(e);
    nb = busy_m;
    nm = map_m;
    if (c1 != 0 && busy_m[ca1] && map_m[ca1] == ct1) nb[ca1] = 1'b0;
    if (c2 != 0 && busy_m[ca2] && map_m[ca2] == ct2) nb[ca2] = 1'b0;
    if (iss != 0 && hd != 0 && dst != 0) begin
      nb[dst] = 1'b1;
      nm[dst] = tg;
    end
    if (fl != 0 || rs != 0) begin
      for (int r = 0; r < 32; r++) begin
        nb[r] = 1'b0;
        nm[r] = 0;
      end
    end
    busy_m = nb;
    map_m  = nm;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic look(input int s1, input int s2);
    step(0, 0, 0, 0, s1, s2, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      busy_m[r] = 1'b0;
      map_m[r]  = 0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state across all registers.
    for (int i = 0; i < 16; i++) look(2 * i, 2 * i + 1);

    // Issue, lookup, commit with matching tag.
    step(1, 1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 5, 1, 5, 7, 0, 0, 0, 0, 0);
    look(5, 0);

    // Younger producer survives commit of the older tag.
    step(1, 1, 5, 7, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 9, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 0, 1, 5, 7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 5, 9, 0, 0);
    look(5, 0);

    // Issue beats commit on the same register.
    step(1, 1, 4, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 12, 4, 4, 1, 4, 3, 0, 0, 0, 0, 0);
    look(4, 4);

    // Both slots on the same register, only one can match.
    step(0, 0, 0, 0, 4, 0, 1, 4, 5, 1, 4, 12, 0, 0);
    look(4, 0);

    // r0 is never renamed; no-dest issue leaves state untouched.
    step(1, 1, 0, 4, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 6, 9, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    look(0, 6);

    // Flush beats a concurrent issue; then the same with reset.
    for (int k = 0; k < 2; k++) begin
      for (int r = 1; r <= 10; r++) step(1, 1, r, r, r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 11, 2, 1, 10, 0, 0, 0, 0, 0, 0, (k == 0) ? 1 : 0, (k == 1) ? 1 : 0);
      look(11, 1);
      look(5, 10);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      int r1, r2, t1, t2;
      r1 = $urandom_range(31);
      r2 = ($urandom_range(3) == 0) ? r1 : $urandom_range(31);
      t1 = ($urandom_range(3) != 0) ? map_m[r1] : $urandom_range(31);
      t2 = ($urandom_range(3) != 0) ? map_m[r2] : $urandom_range(31);
      step(($urandom_range(9) < 7) ? 1 : 0, ($urandom_range(7) != 0) ? 1 : 0,
           $urandom_range(31), $urandom_range(31),
           $urandom_range(31), $urandom_range(31),
           $urandom_range(1), r1, t1,
           $urandom_range(1), r2, t2,
           ($urandom_range(63) == 0) ? 1 : 0, ($urandom_range(127) == 0) ? 1 : 0);
    end

    @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
